// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
// Detects load-use and multiply/divide hazards and reacts to taken branches.
// From these it drives the PC/FD hold, DX hold, DX bubble and FD flush controls.
// It also keeps a sticky multdiv timeout flag and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int unsigned MD_TIMEOUT = 63
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] InstrFD,
   input  logic [31:0] InstrDX,
   input  logic        branch_taken,
   input  logic        md_ready,
   output logic        stall_F,
   output logic        stall_X,
   output logic        bubble_DX,
   output logic        flush_FD,
   output logic        md_busy,
   output logic        md_timeout,
   output logic [15:0] stall_count
);

   // Opcode and ALU-op encodings used by the hazard checks
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   // The last MD_WAIT cycle is the one whose counter value is MD_TIMEOUT-1.
   // The counter therefore reaches MD_TIMEOUT on the exit edge, giving MD_TIMEOUT wait cycles.
   localparam logic [5:0] WAIT_LAST = 6'(MD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN,
      LU_STALL,
      MD_WAIT,
      FLUSH
   } stateT;

   stateT      state;
   logic [5:0] waitCnt;

   // Field decode of the latched FD and DX instructions
   logic [4:0] fdOp, fdRd, fdRs, fdRt;
   logic [4:0] dxOp, dxRd, dxAlu;

   assign fdOp  = InstrFD[31:27];
   assign fdRd  = InstrFD[26:22];
   assign fdRs  = InstrFD[21:17];
   assign fdRt  = InstrFD[16:12];
   assign dxOp  = InstrDX[31:27];
   assign dxRd  = InstrDX[26:22];
   assign dxAlu = InstrDX[6:2];

   logic fdIsRType;
   logic fdReadsRd;
   logic dxIsLoad;
   logic luHit;
   logic mdStart;
   logic timeoutHit;

   // Classify the decode instruction and detect the two hazard kinds
   always_comb begin
      fdIsRType = (fdOp == OP_RTYPE);
      // sw, bne, blt and jr read their rd field as a source operand
      fdReadsRd = (fdOp == OP_SW) || (fdOp == OP_BNE) ||
                  (fdOp == OP_BLT) || (fdOp == OP_JR);
      dxIsLoad  = (dxOp == OP_LW) && (dxRd != '0);
      luHit     = dxIsLoad &&
                  ((dxRd == fdRs) ||
                   (fdIsRType && (dxRd == fdRt)) ||
                   (fdReadsRd && (dxRd == fdRd)));
      mdStart   = (dxOp == OP_RTYPE) &&
                  ((dxAlu == ALU_MUL) || (dxAlu == ALU_DIV));
      timeoutHit = (waitCnt == WAIT_LAST);
   end

   logic stallXRaw;

   // Pipeline control outputs from current state and hazards; all held low in reset
   always_comb begin
      stall_F   = 1'b0;
      stallXRaw = 1'b0;
      bubble_DX = 1'b0;
      flush_FD  = 1'b0;
      if (reset_n) begin
         unique case (state)
            RUN: begin
               if (branch_taken) begin
                  flush_FD  = 1'b1;
                  bubble_DX = 1'b1;
               end else if (mdStart) begin
                  stall_F   = 1'b1;
                  stallXRaw = 1'b1;
               end else if (luHit) begin
                  stall_F   = 1'b1;
                  bubble_DX = 1'b1;
               end
            end
            MD_WAIT: begin
               if (!md_ready) begin
                  stall_F   = 1'b1;
                  stallXRaw = 1'b1;
               end
            end
            FLUSH: begin
               flush_FD  = 1'b1;
               bubble_DX = 1'b1;
            end
            default: begin
            end
         endcase
      end
      // A bubble into DX always wins over holding DX
      stall_X = stallXRaw & ~bubble_DX;
   end

   assign md_busy = (state == MD_WAIT);

   // Hazard FSM with multdiv wait counter and sticky timeout flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         waitCnt    <= '0;
         md_timeout <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (branch_taken) begin
                  state <= FLUSH;
               end else if (mdStart) begin
                  state   <= MD_WAIT;
                  waitCnt <= '0;
               end else if (luHit) begin
                  state <= LU_STALL;
               end
            end
            LU_STALL: begin
               state <= RUN;
            end
            MD_WAIT: begin
               // branch_taken is not looked at here: X is frozen on the multdiv op
               waitCnt <= waitCnt + 6'd1;
               if (md_ready) begin
                  state <= RUN;
               end else if (timeoutHit) begin
                  state      <= RUN;
                  md_timeout <= 1'b1;
               end
            end
            FLUSH: begin
               state <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   // Saturating count of cycles in which fetch was held
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (stall_F && (stall_count != '1)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_hazard_stall_ctrl;

   logic        clock;
   logic        reset_n;
   logic [31:0] InstrFD;
   logic [31:0] InstrDX;
   logic        branch_taken;
   logic        md_ready;
   logic        stall_F;
   logic        stall_X;
   logic        bubble_DX;
   logic        flush_FD;
   logic        md_busy;
   logic        md_timeout;
   logic [15:0] stall_count;

   // Packed view of the controls: {stall_F, stall_X, bubble_DX, flush_FD, md_busy}
   logic [4:0] outs;
   assign outs = {stall_F, stall_X, bubble_DX, flush_FD, md_busy};

   int nCmp;
   int nBad;
   logic [15:0] expCount;

   localparam logic [31:0] NOP = 32'd0;

   hazard_stall_ctrl #(.MD_TIMEOUT(63)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .InstrFD     (InstrFD),
      .InstrDX     (InstrDX),
      .branch_taken(branch_taken),
      .md_ready    (md_ready),
      .stall_F     (stall_F),
      .stall_X     (stall_X),
      .bubble_DX   (bubble_DX),
      .flush_FD    (flush_FD),
      .md_busy     (md_busy),
      .md_timeout  (md_timeout),
      .stall_count (stall_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] mkR(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] alu);
      return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction

   function automatic logic [31:0] mkI(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic test_reset();
      reset_n      = 1'b0;
      branch_taken = 1'b1;
      md_ready     = 1'b0;
      InstrDX      = mkI(5'b01000, 5'd5, 5'd2, 17'd0);
      InstrFD      = mkR(5'd7, 5'd5, 5'd3, 5'd0);
      #1;
      nCmp++;
      if (outs !== 5'b00000) begin
         nBad++;
         $display("FAIL reset_outs: got %b want %b", outs, 5'b00000);
      end
      nCmp++;
      if (stall_count !== 16'h0000) begin
         nBad++;
         $display("FAIL reset_count: got %h want %h", stall_count, 16'h0000);
      end
      nCmp++;
      if (md_timeout !== 1'b0) begin
         nBad++;
         $display("FAIL reset_timeout: got %b want %b", md_timeout, 1'b0);
      end
      @(negedge clock);
      branch_taken = 1'b0;
      InstrDX      = NOP;
      InstrFD      = NOP;
      reset_n      = 1'b1;
      expCount     = 16'd0;
      @(negedge clock);
      #1;
      nCmp++;
      if (outs !== 5'b00000) begin
         nBad++;
         $display("FAIL post_reset_outs: got %b want %b", outs, 5'b00000);
      end
   endtask

   task automatic test_load_use();
      logic [31:0] dxV [7];
      logic [31:0] fdV [7];
      logic        hitV[7];
      dxV[0] = mkI(5'b01000, 5'd5, 5'd2, 17'd0); fdV[0] = mkR(5'd7, 5'd5, 5'd3, 5'd0); hitV[0] = 1'b1;
      dxV[1] = mkI(5'b01000, 5'd0, 5'd2, 17'd0); fdV[1] = mkR(5'd7, 5'd0, 5'd0, 5'd0); hitV[1] = 1'b0;
      dxV[2] = mkI(5'b01000, 5'd6, 5'd1, 17'd0); fdV[2] = mkR(5'd7, 5'd2, 5'd6, 5'd0); hitV[2] = 1'b1;
      dxV[3] = mkI(5'b01000, 5'd6, 5'd1, 17'd0); fdV[3] = mkI(5'b00111, 5'd6, 5'd1, 17'd4); hitV[3] = 1'b1;
      dxV[4] = mkI(5'b01000, 5'd6, 5'd1, 17'd0); fdV[4] = mkI(5'b00101, 5'd6, 5'd1, 17'h06000); hitV[4] = 1'b0;
      dxV[5] = mkI(5'b01000, 5'd6, 5'd1, 17'd0); fdV[5] = mkI(5'b00100, 5'd6, 5'd0, 17'd0); hitV[5] = 1'b1;
      dxV[6] = mkI(5'b01000, 5'd6, 5'd1, 17'd0); fdV[6] = mkI(5'b00101, 5'd9, 5'd6, 17'd1); hitV[6] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         InstrDX = dxV[i];
         InstrFD = fdV[i];
         #1;
         nCmp++;
         if (outs !== (hitV[i] ? 5'b10100 : 5'b00000)) begin
            nBad++;
            $display("FAIL load_use_%0d: got %b want %b", i, outs, hitV[i] ? 5'b10100 : 5'b00000);
         end
         if (hitV[i]) expCount = expCount + 16'd1;
         @(negedge clock);
         InstrDX = NOP;
         #1;
         nCmp++;
         if (outs !== 5'b00000) begin
            nBad++;
            $display("FAIL load_use_after_%0d: got %b want %b", i, outs, 5'b00000);
         end
         @(negedge clock);
         #1;
         nCmp++;
         if (stall_count !== expCount) begin
            nBad++;
            $display("FAIL load_use_count_%0d: got %0d want %0d", i, stall_count, expCount);
         end
      end
   endtask

   task automatic test_multdiv();
      @(negedge clock);
      InstrDX = mkR(5'd4, 5'd2, 5'd3, 5'b00110);
      InstrFD = mkR(5'd8, 5'd1, 5'd1, 5'd0);
      md_ready = 1'b0;
      #1;
      nCmp++;
      if (outs !== 5'b11000) begin
         nBad++;
         $display("FAIL md_start: got %b want %b", outs, 5'b11000);
      end
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         branch_taken = (k == 5);
         #1;
         nCmp++;
         if (outs !== 5'b11001) begin
            nBad++;
            $display("FAIL md_wait_%0d: got %b want %b", k, outs, 5'b11001);
         end
      end
      @(negedge clock);
      branch_taken = 1'b0;
      md_ready     = 1'b1;
      #1;
      nCmp++;
      if (outs !== 5'b00001) begin
         nBad++;
         $display("FAIL md_ready_cycle: got %b want %b", outs, 5'b00001);
      end
      @(negedge clock);
      md_ready = 1'b0;
      InstrDX  = NOP;
      expCount = expCount + 16'd17;
      #1;
      nCmp++;
      if (outs !== 5'b00000) begin
         nBad++;
         $display("FAIL md_done_outs: got %b want %b", outs, 5'b00000);
      end
      nCmp++;
      if (md_timeout !== 1'b0) begin
         nBad++;
         $display("FAIL md_done_timeout: got %b want %b", md_timeout, 1'b0);
      end
      nCmp++;
      if (stall_count !== expCount) begin
         nBad++;
         $display("FAIL md_count: got %0d want %0d", stall_count, expCount);
      end
   endtask

   task automatic test_timeout();
      @(negedge clock);
      InstrDX = mkR(5'd4, 5'd2, 5'd3, 5'b00111);
      #1;
      nCmp++;
      if (outs !== 5'b11000) begin
         nBad++;
         $display("FAIL div_start: got %b want %b", outs, 5'b11000);
      end
      for (int k = 1; k <= 63; k++) begin
         @(negedge clock);
         #1;
         nCmp++;
         if (outs !== 5'b11001) begin
            nBad++;
            $display("FAIL div_wait_%0d: got %b want %b", k, outs, 5'b11001);
         end
      end
      nCmp++;
      if (md_timeout !== 1'b0) begin
         nBad++;
         $display("FAIL timeout_early: got %b want %b", md_timeout, 1'b0);
      end
      @(negedge clock);
      InstrDX  = NOP;
      expCount = expCount + 16'd64;
      #1;
      nCmp++;
      if (outs !== 5'b00000) begin
         nBad++;
         $display("FAIL timeout_exit_outs: got %b want %b", outs, 5'b00000);
      end
      nCmp++;
      if (md_timeout !== 1'b1) begin
         nBad++;
         $display("FAIL timeout_flag: got %b want %b", md_timeout, 1'b1);
      end
      nCmp++;
      if (stall_count !== expCount) begin
         nBad++;
         $display("FAIL timeout_count: got %0d want %0d", stall_count, expCount);
      end
      @(negedge clock);
      @(negedge clock);
      #1;
      nCmp++;
      if (md_timeout !== 1'b1) begin
         nBad++;
         $display("FAIL timeout_sticky: got %b want %b", md_timeout, 1'b1);
      end
   endtask

   task automatic test_priority();
      logic [31:0] dxV[2];
      dxV[0] = mkI(5'b01000, 5'd5, 5'd2, 17'd0);
      dxV[1] = mkR(5'd4, 5'd2, 5'd3, 5'b00110);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         InstrDX      = dxV[i];
         InstrFD      = mkR(5'd7, 5'd5, 5'd3, 5'd0);
         branch_taken = 1'b1;
         #1;
         nCmp++;
         if (outs !== 5'b00110) begin
            nBad++;
            $display("FAIL prio_branch_%0d: got %b want %b", i, outs, 5'b00110);
         end
         @(negedge clock);
         InstrDX      = NOP;
         InstrFD      = NOP;
         branch_taken = 1'b0;
         #1;
         nCmp++;
         if (outs !== 5'b00110) begin
            nBad++;
            $display("FAIL prio_flush_%0d: got %b want %b", i, outs, 5'b00110);
         end
         @(negedge clock);
         #1;
         nCmp++;
         if (outs !== 5'b00000) begin
            nBad++;
            $display("FAIL prio_run_%0d: got %b want %b", i, outs, 5'b00000);
         end
         nCmp++;
         if (stall_count !== expCount) begin
            nBad++;
            $display("FAIL prio_count_%0d: got %0d want %0d", i, stall_count, expCount);
         end
      end
   endtask

   task automatic test_reset_mid_md();
      @(negedge clock);
      InstrDX = mkR(5'd4, 5'd2, 5'd3, 5'b00111);
      repeat (5) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      nCmp++;
      if (outs !== 5'b00000) begin
         nBad++;
         $display("FAIL rst_md_outs: got %b want %b", outs, 5'b00000);
      end
      nCmp++;
      if (stall_count !== 16'h0000) begin
         nBad++;
         $display("FAIL rst_md_count: got %h want %h", stall_count, 16'h0000);
      end
      nCmp++;
      if (md_timeout !== 1'b0) begin
         nBad++;
         $display("FAIL rst_md_timeout: got %b want %b", md_timeout, 1'b0);
      end
      @(negedge clock);
      InstrDX = NOP;
      reset_n = 1'b1;
      @(negedge clock);
      #1;
      nCmp++;
      if (outs !== 5'b00000) begin
         nBad++;
         $display("FAIL rst_md_after: got %b want %b", outs, 5'b00000);
      end
      nCmp++;
      if (stall_count !== 16'h0000) begin
         nBad++;
         $display("FAIL rst_md_after_count: got %h want %h", stall_count, 16'h0000);
      end
   endtask

   // A div held in DX with no md_ready stalls every cycle (timeouts re-enter MD_WAIT)
   task automatic test_saturate();
      @(negedge clock);
      InstrDX = mkR(5'd4, 5'd2, 5'd3, 5'b00111);
      repeat (65534) @(posedge clock);
      #1;
      nCmp++;
      if (stall_count !== 16'hFFFE) begin
         nBad++;
         $display("FAIL sat_fffe: got %h want %h", stall_count, 16'hFFFE);
      end
      @(posedge clock);
      #1;
      nCmp++;
      if (stall_count !== 16'hFFFF) begin
         nBad++;
         $display("FAIL sat_ffff: got %h want %h", stall_count, 16'hFFFF);
      end
      repeat (3) @(posedge clock);
      #1;
      nCmp++;
      if (stall_F !== 1'b1) begin
         nBad++;
         $display("FAIL sat_stalling: got %b want %b", stall_F, 1'b1);
      end
      nCmp++;
      if (stall_count !== 16'hFFFF) begin
         nBad++;
         $display("FAIL sat_hold: got %h want %h", stall_count, 16'hFFFF);
      end
      @(negedge clock);
      InstrDX = NOP;
   endtask

   initial begin
      nCmp = 0;
      nBad = 0;
      test_reset();
      test_load_use();
      test_multdiv();
      test_timeout();
      test_priority();
      test_reset_mid_md();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
